// File: rtl/debug_uart_fifo_tx_if.sv
// ----------------------------------------------------------------------------
// debug_uart_fifo_tx_if
//   tinyQV data-bus view of the debug UART transmitter.
//
//   addr          word select (bus addr[3:2]): 0 DATA, 1 STATUS, 2 CTRL, 3 rsvd
//   data_write_n  2'b11 = idle, any other value = write this cycle
//   data_read_n   2'b11 = idle, any other value = read this cycle
//   data_in       write data
//   data_out      read data, combinational from addr
//   data_ready    always 1: every access completes in one cycle
//
//   master = bus host (CPU / testbench), slave = peripheral.
// ----------------------------------------------------------------------------
interface debug_uart_fifo_tx_if;
  logic [1:0]  addr;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        data_ready;

  modport master (
    output addr, data_write_n, data_read_n, data_in,
    input  data_out, data_ready
  );

  modport slave (
    input  addr, data_write_n, data_read_n, data_in,
    output data_out, data_ready
  );
endinterface

// File: rtl/debug_uart_fifo_tx.sv
// ----------------------------------------------------------------------------
// debug_uart_fifo_tx
//   Debug UART transmitter with a byte FIFO, programmable baud divisor,
//   1 or 2 stop bits, sticky overflow flag and a FIFO-level interrupt.
//
//   Registers (word address on bus.addr):
//     0 DATA   W: push data_in[7:0] (dropped + overflow if full)   R: 0
//     1 STATUS R: {count @ [8+:CNT_W], overflow, empty, full, busy}
//              W: bit3 = 1 clears overflow
//     2 CTRL   R/W: [DIV_W-1:0] divisor, [16] two_stop, [27:24] thresh,
//              [31] irq_en
//     3 rsvd   R: 0, writes ignored
//
//   Ports:
//     clk       system clock
//     rst       synchronous reset, active high
//     bus       tinyQV peripheral bus (slave side)
//     uart_txd  serial output, idle high
//     tx_busy   FIFO non-empty or a frame in progress
//     irq       irq_en && (count <= thresh), registered
// ----------------------------------------------------------------------------
module debug_uart_fifo_tx #(
  parameter int CLOCK_MHZ    = 64,
  parameter int DEFAULT_BAUD = 4_000_000,
  parameter int DIV_W        = 12,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  debug_uart_fifo_tx_if.slave        bus,
  output logic                       uart_txd,
  output logic                       tx_busy,
  output logic                       irq
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [DIV_W-1:0] RESET_DIV =
    DIV_W'(CLOCK_MHZ * 1_000_000 / DEFAULT_BAUD - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_e;

  // Shifter state
  state_e           state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [DIV_W-1:0] frame_div_q, frame_div_d;
  logic             frame_two_stop_q, frame_two_stop_d;

  // FIFO
  logic [7:0]       fifo_mem_q [FIFO_DEPTH];
  logic [7:0]       fifo_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  // Control register and interrupt
  logic [DIV_W-1:0] div_q, div_d;
  logic             two_stop_q, two_stop_d;
  logic [3:0]       thresh_q, thresh_d;
  logic             irq_en_q, irq_en_d;
  logic             irq_q, irq_d;

  logic wr_en, push_req, status_wr, ctrl_wr;
  logic fifo_full, fifo_empty, push, pop, baud_tick;
  logic [31:0] status_rd, ctrl_rd;

  // Reads have no side effects, so the read strobe and the undecoded
  // write-data bits are intentionally left unconsumed.
  logic unused_bus_bits;
  assign unused_bus_bits = &{1'b0, bus.data_read_n, bus.data_in};

  assign wr_en     = (bus.data_write_n != 2'b11);
  assign push_req  = wr_en && (bus.addr == 2'd0);
  assign status_wr = wr_en && (bus.addr == 2'd1);
  assign ctrl_wr   = wr_en && (bus.addr == 2'd2);

  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign pop        = (state_q == ST_IDLE) && !fifo_empty;
  // The pop frees a slot in the same cycle, so a full FIFO still accepts.
  assign push       = push_req && (!fifo_full || pop);
  assign baud_tick  = (baud_cnt_q == frame_div_q);

  // --------------------------------------------------------------------------
  // Register-file / FIFO next state
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise synthesis would infer a latch to hold it.
    fifo_mem_d = fifo_mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    overflow_d = overflow_q;
    div_d      = div_q;
    two_stop_d = two_stop_q;
    thresh_d   = thresh_q;
    irq_en_d   = irq_en_q;

    if (push) begin
      fifo_mem_d[wr_ptr_q] = bus.data_in[7:0];
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    // Setting has priority over a same-cycle software clear.
    if (push_req && !push) begin
      overflow_d = 1'b1;
    end else if (status_wr && bus.data_in[3]) begin
      overflow_d = 1'b0;
    end

    if (ctrl_wr) begin
      div_d      = bus.data_in[DIV_W-1:0];
      two_stop_d = bus.data_in[16];
      thresh_d   = bus.data_in[27:24];
      irq_en_d   = bus.data_in[31];
    end

    irq_d = irq_en_d && (32'(count_d) <= 32'(thresh_d));
  end

  // --------------------------------------------------------------------------
  // Shifter FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d          = state_q;
    shift_d          = shift_q;
    bit_cnt_d        = bit_cnt_q;
    frame_div_d      = frame_div_q;
    frame_two_stop_d = frame_two_stop_q;
    baud_cnt_d       = baud_tick ? '0 : baud_cnt_q + DIV_W'(1);

    unique case (state_q)
      ST_IDLE: begin
        baud_cnt_d = '0;
        if (pop) begin
          // Frame timing is frozen here; CTRL writes mid-frame wait.
          shift_d          = fifo_mem_q[rd_ptr_q];
          frame_div_d      = div_q;
          frame_two_stop_d = two_stop_q;
          bit_cnt_d        = '0;
          state_d          = ST_START;
        end
      end
      ST_START: begin
        if (baud_tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (baud_tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            // bit_cnt is reused as "stop bits remaining minus one".
            bit_cnt_d = {2'b00, frame_two_stop_q};
            state_d   = ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (baud_tick) begin
          if (bit_cnt_q == '0) state_d = ST_IDLE;
          else                 bit_cnt_d = bit_cnt_q - 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Shifter FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    unique case (state_q)
      ST_START: uart_txd = 1'b0;
      ST_DATA:  uart_txd = shift_q[0];
      default:  uart_txd = 1'b1;
    endcase
    tx_busy = !fifo_empty || (state_q != ST_IDLE);
    irq     = irq_q;
  end

  // --------------------------------------------------------------------------
  // Read mux
  // --------------------------------------------------------------------------
  always_comb begin
    status_rd              = '0;
    status_rd[0]           = tx_busy;
    status_rd[1]           = fifo_full;
    status_rd[2]           = fifo_empty;
    status_rd[3]           = overflow_q;
    status_rd[8 +: CNT_W]  = count_q;

    ctrl_rd                = '0;
    ctrl_rd[DIV_W-1:0]     = div_q;
    ctrl_rd[16]            = two_stop_q;
    ctrl_rd[27:24]         = thresh_q;
    ctrl_rd[31]            = irq_en_q;

    unique case (bus.addr)
      2'd1:    bus.data_out = status_rd;
      2'd2:    bus.data_out = ctrl_rd;
      default: bus.data_out = '0;
    endcase
  end

  assign bus.data_ready = 1'b1;

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      shift_q          <= '0;
      bit_cnt_q        <= '0;
      baud_cnt_q       <= '0;
      frame_div_q      <= RESET_DIV;
      frame_two_stop_q <= 1'b0;
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      count_q          <= '0;
      overflow_q       <= 1'b0;
      div_q            <= RESET_DIV;
      two_stop_q       <= 1'b0;
      thresh_q         <= '0;
      irq_en_q         <= 1'b0;
      irq_q            <= 1'b0;
    end else begin
      state_q          <= state_d;
      shift_q          <= shift_d;
      bit_cnt_q        <= bit_cnt_d;
      baud_cnt_q       <= baud_cnt_d;
      frame_div_q      <= frame_div_d;
      frame_two_stop_q <= frame_two_stop_d;
      rd_ptr_q         <= rd_ptr_d;
      wr_ptr_q         <= wr_ptr_d;
      count_q          <= count_d;
      overflow_q       <= overflow_d;
      div_q            <= div_d;
      two_stop_q       <= two_stop_d;
      thresh_q         <= thresh_d;
      irq_en_q         <= irq_en_d;
      irq_q            <= irq_d;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; the pointers and count
  // are, so stale entries can never be read and the array maps to plain RAM.
  always_ff @(posedge clk) begin
    fifo_mem_q <= fifo_mem_d;
  end

endmodule

// File: tb/tb_debug_uart_fifo_tx.sv
// ----------------------------------------------------------------------------
// tb_debug_uart_fifo_tx
//   Directed bench for debug_uart_fifo_tx: register vector table plus
//   hand-written frame, FIFO, divisor, stop-bit, irq and reset sequences.
//   Inputs change just after a rising edge; outputs are sampled there too.
// ----------------------------------------------------------------------------
module tb_debug_uart_fifo_tx;

  logic clk = 1'b0;
  logic rst;
  logic uart_txd, tx_busy, irq;

  debug_uart_fifo_tx_if bus ();

  debug_uart_fifo_tx dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .uart_txd (uart_txd),
    .tx_busy  (tx_busy),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.addr         = a;
    bus.data_in      = d;
    bus.data_write_n = 2'b00;
    @(posedge clk);
    #1;
    bus.data_write_n = 2'b11;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus.addr        = a;
    bus.data_read_n = 2'b00;
    #1;
    d               = bus.data_out;
    bus.data_read_n = 2'b11;
  endtask

  // Checks one whole frame clock by clock; one comparison per bit slot.
  // Entry: sampling the first start-bit clock. Exit: first clock after stop.
  task automatic expect_frame(input string tag, input logic [7:0] b,
                              input int bc, input int n_stop);
    int bad;
    bad = 0;
    repeat (bc) begin
      if (uart_txd !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    check({tag, "_start"}, bad, 0);
    for (int i = 0; i < 8; i++) begin
      bad = 0;
      repeat (bc) begin
        if (uart_txd !== b[i]) bad++;
        @(posedge clk); #1;
      end
      check($sformatf("%s_bit%0d", tag, i), bad, 0);
    end
    bad = 0;
    repeat (bc * n_stop) begin
      if (uart_txd !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    check({tag, "_stop"}, bad, 0);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (tx_busy !== 1'b0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_idle_timeout"}, tx_busy, 0);
  endtask

  // Independent receiver: mid-bit sampling at rx_bc clocks per bit.
  bit         rx_en = 1'b0;
  int         rx_bc = 16;
  int         rx_frame_err = 0;
  logic [7:0] rx_q [$];
  int         rx_pos;
  logic [7:0] rx_byte;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rx_en && uart_txd === 1'b0) begin
        rx_pos = 0;
        for (int i = 0; i < 8; i++) begin
          while (rx_pos < rx_bc * (1 + i) + rx_bc / 2) begin
            @(posedge clk); #1;
            rx_pos++;
          end
          rx_byte[i] = uart_txd;
        end
        while (rx_pos < rx_bc * 9 + rx_bc / 2) begin
          @(posedge clk); #1;
          rx_pos++;
        end
        if (uart_txd !== 1'b1) rx_frame_err++;
        rx_q.push_back(rx_byte);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_irq;
    string       name;
  } vec_t;

  vec_t        vecs [10];
  logic [31:0] rd;
  int          bad;

  initial begin
    vecs[0] = '{1'b0, 2'd1, 32'h0,        32'h0000_0004, 1'b0, "status_rst"};
    vecs[1] = '{1'b0, 2'd2, 32'h0,        32'h0000_000F, 1'b0, "ctrl_rst"};
    vecs[2] = '{1'b0, 2'd0, 32'h0,        32'h0000_0000, 1'b0, "data_reads_0"};
    vecs[3] = '{1'b0, 2'd3, 32'h0,        32'h0000_0000, 1'b0, "rsvd_reads_0"};
    vecs[4] = '{1'b1, 2'd2, 32'h8301_0005, 32'h8301_0005, 1'b1, "ctrl_wr_a"};
    vecs[5] = '{1'b1, 2'd2, 32'hFFFF_FFFF, 32'h8F01_0FFF, 1'b1, "ctrl_wr_mask"};
    vecs[6] = '{1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, "rsvd_wr"};
    vecs[7] = '{1'b0, 2'd2, 32'h0,        32'h8F01_0FFF, 1'b1, "ctrl_after_rsvd"};
    vecs[8] = '{1'b1, 2'd1, 32'hFFFF_FFFF, 32'h0000_0004, 1'b1, "status_wr"};
    vecs[9] = '{1'b1, 2'd2, 32'h0000_000F, 32'h0000_000F, 1'b0, "ctrl_default"};

    bus.addr         = 2'd0;
    bus.data_in      = '0;
    bus.data_write_n = 2'b11;
    bus.data_read_n  = 2'b11;
    rst              = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_txd", uart_txd, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_irq", irq, 0);
    check("data_ready", bus.data_ready, 1);
    rst = 1'b0;

    // ---- register vector table ----
    foreach (vecs[k]) begin
      if (vecs[k].wr) bus_write(vecs[k].addr, vecs[k].wdata);
      bus_read(vecs[k].addr, rd);
      check(vecs[k].name, rd, vecs[k].exp_rd);
      check({vecs[k].name, "_irq"}, irq, vecs[k].exp_irq);
      @(posedge clk); #1;
    end

    // ---- single byte, divisor 15 ----
    bus_write(2'd0, 32'h55);
    check("lat_txd_still_idle", uart_txd, 1);
    check("lat_busy", tx_busy, 1);
    @(posedge clk); #1;
    expect_frame("f55", 8'h55, 16, 1);
    check("f55_busy_fall", tx_busy, 0);
    check("f55_txd_idle", uart_txd, 1);

    // ---- FIFO fill and overflow ----
    rx_q.delete();
    rx_frame_err = 0;
    rx_bc        = 16;
    rx_en        = 1'b1;
    for (int i = 0; i < 10; i++) bus_write(2'd0, 32'h10 + i);
    bus_read(2'd1, rd);
    check("fifo_full_status", rd, 32'h0000_080B);
    bus_write(2'd1, 32'h8);
    bus_read(2'd1, rd);
    check("ovf_cleared", rd, 32'h0000_0803);
    wait_idle("fifo_drain", 3000);
    check("rx_frames", rx_q.size(), 9);
    for (int i = 0; i < 9; i++) begin
      if (i < rx_q.size()) check($sformatf("rx_byte%0d", i), rx_q[i], 32'h10 + i);
    end
    check("rx_framing", rx_frame_err, 0);
    rx_en = 1'b0;

    // ---- divisor change mid-frame ----
    bus_write(2'd0, 32'hA3);
    bus_write(2'd0, 32'h3C);
    fork
      expect_frame("fa3", 8'hA3, 16, 1);
      begin
        repeat (20) @(posedge clk);
        #1;
        bus_write(2'd2, 32'h0000_0003);
      end
    join
    check("div_gap_txd", uart_txd, 1);
    @(posedge clk); #1;
    expect_frame("f3c", 8'h3C, 4, 1);
    check("f3c_busy_fall", tx_busy, 0);

    // ---- two stop bits, divisor 0 ----
    bus_write(2'd2, 32'h0001_0000);
    bus_write(2'd0, 32'hFF);
    bus_write(2'd0, 32'h00);
    expect_frame("fff", 8'hFF, 1, 2);
    check("stop2_gap_txd", uart_txd, 1);
    @(posedge clk); #1;
    expect_frame("f00", 8'h00, 1, 2);
    check("f00_busy_fall", tx_busy, 0);

    // ---- irq threshold ----
    bus_write(2'd2, 32'h8200_000F);
    check("irq_empty", irq, 1);
    for (int i = 0; i < 6; i++) bus_write(2'd0, 32'h60 + i);
    bus_read(2'd1, rd);
    check("irq_q5_status", rd, 32'h0000_0501);
    check("irq_q5", irq, 0);
    repeat (478) @(posedge clk);
    #1;
    bus_read(2'd1, rd);
    check("irq_q3_status", rd, 32'h0000_0301);
    check("irq_q3", irq, 0);
    @(posedge clk); #1;
    bus_read(2'd1, rd);
    check("irq_q2_status", rd, 32'h0000_0201);
    check("irq_q2_rise", irq, 1);
    bus_write(2'd2, 32'h0200_000F);
    check("irq_disabled", irq, 0);
    bad = 0;
    for (int n = 0; n < 1500 && tx_busy !== 1'b0; n++) begin
      if (irq !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    check("irq_stays_low", bad, 0);
    check("irq_drain_timeout", tx_busy, 0);

    // ---- reset mid-frame (byte 3 of 5, in its data bits) ----
    bus_write(2'd2, 32'h8300_000F);
    for (int i = 0; i < 5; i++) bus_write(2'd0, 32'hC0 + i);
    repeat (340) @(posedge clk);
    #1;
    check("pre_rst_busy", tx_busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_txd", uart_txd, 1);
    check("midrst_busy", tx_busy, 0);
    check("midrst_irq", irq, 0);
    bus_read(2'd1, rd);
    check("midrst_status", rd, 32'h0000_0004);
    bus_read(2'd2, rd);
    check("midrst_ctrl", rd, 32'h0000_000F);
    bad = 0;
    repeat (600) begin
      @(posedge clk); #1;
      if (uart_txd !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    check("midrst_quiet", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
